// File: rtl/histogram_peak_finder.sv
// histogram_peak_finder
// Requests one x/y histogram bin stream per frame, tracks the peak bin
// (index and count) of each axis, clears the histogram stage and reports
// whether both peaks reach THRESHOLD. A frame is aborted if no bin strobe
// arrives for TIMEOUT consecutive collect cycles.
// Optional feature macro: PEAK_BBOX_EN adds per-axis first/last bin index
// whose count reaches THRESHOLD (xMin/xMax/yMin/yMax).
module histogram_peak_finder #(
  parameter int X_BINS    = 240,
  parameter int Y_BINS    = 180,
  parameter int THRESHOLD = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       histReady,
  output logic       readHistogram,
  output logic       clearHistogram,
  input  logic       histogramClear,
  input  logic [7:0] xHistogramIn,
  input  logic       xValid,
  input  logic [7:0] yHistogramIn,
  input  logic       yValid,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       timeoutErr,
  output logic [7:0] xPeak,
  output logic [7:0] yPeak,
  output logic [7:0] xPeakCount,
  output logic [7:0] yPeakCount
`ifdef PEAK_BBOX_EN
  ,
  output logic [7:0] xMin,
  output logic [7:0] xMax,
  output logic [7:0] yMin,
  output logic [7:0] yMax
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    COLLECT,
    CLEAR,
    DONE
  } state_t;

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0] X_LAST = 8'(X_BINS);
  localparam logic [7:0] Y_LAST = 8'(Y_BINS);
  localparam logic [7:0] THR = 8'(THRESHOLD);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic clear_first_q, clear_first_d;
  logic [7:0] x_cnt_q, x_cnt_d;
  logic [7:0] y_cnt_q, y_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [7:0] x_peak_q, x_peak_d;
  logic [7:0] x_max_q, x_max_d;
  logic [7:0] y_peak_q, y_peak_d;
  logic [7:0] y_max_q, y_max_d;
  logic found_q, found_d;
  logic timeout_q, timeout_d;

`ifdef PEAK_BBOX_EN
  logic [7:0] x_lo_q, x_lo_d;
  logic [7:0] x_hi_q, x_hi_d;
  logic [7:0] y_lo_q, y_lo_d;
  logic [7:0] y_hi_q, y_hi_d;
  logic x_any_q, x_any_d;
  logic y_any_q, y_any_d;
`endif

  logic accept;
  logic x_take;
  logic y_take;
  logic any_strobe;
  logic streams_full;
  logic peaks_ok;

  // Qualifiers shared by the next-state logic: a start is only taken from IDLE
  // with the histogram stage ready, and strobes past the last bin are dropped.
  always_comb begin
    accept       = (state_q == IDLE) && start && histReady;
    x_take       = (state_q == COLLECT) && xValid && (x_cnt_q != X_LAST);
    y_take       = (state_q == COLLECT) && yValid && (y_cnt_q != Y_LAST);
    any_strobe   = xValid || yValid;
    streams_full = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);
`ifdef PEAK_BBOX_EN
    peaks_ok = (x_max_q >= THR) && (y_max_q >= THR) && !timeout_q &&
               x_any_q && y_any_q;
`else
    peaks_ok = (x_max_q >= THR) && (y_max_q >= THR) && !timeout_q;
`endif
  end

  // Next-state and datapath update: FSM sequencing plus per-axis peak tracking.
  always_comb begin
    state_d       = state_q;
    clear_first_d = clear_first_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    idle_d        = idle_q;
    x_peak_d      = x_peak_q;
    x_max_d       = x_max_q;
    y_peak_d      = y_peak_q;
    y_max_d       = y_max_q;
    found_d       = found_q;
    timeout_d     = timeout_q;
`ifdef PEAK_BBOX_EN
    x_lo_d  = x_lo_q;
    x_hi_d  = x_hi_q;
    y_lo_d  = y_lo_q;
    y_hi_d  = y_hi_q;
    x_any_d = x_any_q;
    y_any_d = y_any_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = REQUEST;
          clear_first_d = 1'b0;
          x_cnt_d       = 8'd0;
          y_cnt_d       = 8'd0;
          idle_d        = '0;
          x_peak_d      = 8'd0;
          x_max_d       = 8'd0;
          y_peak_d      = 8'd0;
          y_max_d       = 8'd0;
          found_d       = 1'b0;
          timeout_d     = 1'b0;
`ifdef PEAK_BBOX_EN
          x_lo_d  = 8'd0;
          x_hi_d  = 8'd0;
          y_lo_d  = 8'd0;
          y_hi_d  = 8'd0;
          x_any_d = 1'b0;
          y_any_d = 1'b0;
`endif
        end
      end

      REQUEST: begin
        state_d = COLLECT;
      end

      COLLECT: begin
        if (x_take) begin
          x_cnt_d = x_cnt_q + 8'd1;
          if (xHistogramIn > x_max_q) begin
            x_max_d  = xHistogramIn;
            x_peak_d = x_cnt_q;
          end
`ifdef PEAK_BBOX_EN
          if (xHistogramIn >= THR) begin
            if (!x_any_q) begin
              x_lo_d = x_cnt_q;
            end
            x_hi_d  = x_cnt_q;
            x_any_d = 1'b1;
          end
`endif
        end

        if (y_take) begin
          y_cnt_d = y_cnt_q + 8'd1;
          if (yHistogramIn > y_max_q) begin
            y_max_d  = yHistogramIn;
            y_peak_d = y_cnt_q;
          end
`ifdef PEAK_BBOX_EN
          if (yHistogramIn >= THR) begin
            if (!y_any_q) begin
              y_lo_d = y_cnt_q;
            end
            y_hi_d  = y_cnt_q;
            y_any_d = 1'b1;
          end
`endif
        end

        if (any_strobe) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end

        if (streams_full) begin
          state_d       = CLEAR;
          clear_first_d = 1'b1;
        end else if (!any_strobe && (idle_q == IDLE_LIMIT)) begin
          timeout_d     = 1'b1;
          state_d       = CLEAR;
          clear_first_d = 1'b1;
        end
      end

      CLEAR: begin
        clear_first_d = 1'b0;
        if (!clear_first_q && histogramClear) begin
          state_d = DONE;
          found_d = peaks_ok;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to zero and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      clear_first_q <= 1'b0;
      x_cnt_q       <= 8'd0;
      y_cnt_q       <= 8'd0;
      idle_q        <= '0;
      x_peak_q      <= 8'd0;
      x_max_q       <= 8'd0;
      y_peak_q      <= 8'd0;
      y_max_q       <= 8'd0;
      found_q       <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef PEAK_BBOX_EN
      x_lo_q  <= 8'd0;
      x_hi_q  <= 8'd0;
      y_lo_q  <= 8'd0;
      y_hi_q  <= 8'd0;
      x_any_q <= 1'b0;
      y_any_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      clear_first_q <= clear_first_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      idle_q        <= idle_d;
      x_peak_q      <= x_peak_d;
      x_max_q       <= x_max_d;
      y_peak_q      <= y_peak_d;
      y_max_q       <= y_max_d;
      found_q       <= found_d;
      timeout_q     <= timeout_d;
`ifdef PEAK_BBOX_EN
      x_lo_q  <= x_lo_d;
      x_hi_q  <= x_hi_d;
      y_lo_q  <= y_lo_d;
      y_hi_q  <= y_hi_d;
      x_any_q <= x_any_d;
      y_any_q <= y_any_d;
`endif
    end
  end

  // Handshake pulses are decoded from the state so reset can never emit one.
  always_comb begin
    readHistogram  = (state_q == REQUEST);
    clearHistogram = (state_q == CLEAR) && clear_first_q;
    done           = (state_q == DONE);
    busy           = (state_q != IDLE);
    found          = found_q;
    timeoutErr     = timeout_q;
    xPeak          = x_peak_q;
    yPeak          = y_peak_q;
    xPeakCount     = x_max_q;
    yPeakCount     = y_max_q;
`ifdef PEAK_BBOX_EN
    xMin = x_lo_q;
    xMax = x_hi_q;
    yMin = y_lo_q;
    yMax = y_hi_q;
`endif
  end

endmodule

// File: tb/tb_histogram_peak_finder.sv
// Testbench for histogram_peak_finder: drives directed and randomized bin
// streams and compares the outputs every cycle with a bin-array model.
module tb_histogram_peak_finder;

  localparam int X_BINS    = 240;
  localparam int Y_BINS    = 180;
  localparam int THRESHOLD = 8;
  localparam int TIMEOUT   = 1023;

  logic clk = 1'b0;
  logic reset, start, histReady, histogramClear;
  logic xValid, yValid;
  logic [7:0] xHistogramIn, yHistogramIn;
  logic readHistogram, clearHistogram, busy, done, found, timeoutErr;
  logic [7:0] xPeak, yPeak, xPeakCount, yPeakCount;
`ifdef PEAK_BBOX_EN
  logic [7:0] xMin, xMax, yMin, yMax;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] xb[X_BINS];
  logic [7:0] yb[Y_BINS];
  int x_sent = 0, y_sent = 0, strobe_total = 0;
  int read_pulses = 0, clear_pulses = 0, done_pulses = 0;
  bit model_active = 1'b0, post_done = 1'b0, exp_timeout = 1'b0, clr_held = 1'b0;

  histogram_peak_finder #(
    .X_BINS(X_BINS), .Y_BINS(Y_BINS), .THRESHOLD(THRESHOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .histReady(histReady),
    .readHistogram(readHistogram), .clearHistogram(clearHistogram),
    .histogramClear(histogramClear),
    .xHistogramIn(xHistogramIn), .xValid(xValid),
    .yHistogramIn(yHistogramIn), .yValid(yValid),
    .busy(busy), .done(done), .found(found), .timeoutErr(timeoutErr),
    .xPeak(xPeak), .yPeak(yPeak), .xPeakCount(xPeakCount), .yPeakCount(yPeakCount)
`ifdef PEAK_BBOX_EN
    , .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan the first n delivered bins of one axis.
  function automatic void modelAxis(input bit isY, input int n, output int idx, output int cnt,
                                    output int lo, output int hi, output bit any);
    int v;
    idx = 0; cnt = 0; lo = 0; hi = 0; any = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (isY) v = int'(yb[i]);
      else v = int'(xb[i]);
      if (v > cnt) begin
        cnt = v;
        idx = i;
      end
      if (v >= THRESHOLD) begin
        if (!any) lo = i;
        hi = i;
        any = 1'b1;
      end
    end
  endfunction

  // Histogram-stage model: acknowledges a clear after a random delay, or holds
  // the acknowledge high for the whole frame when clr_held is set.
  initial begin
    int d;
    histogramClear = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_held) begin
        histogramClear = 1'b1;
      end else if (clearHistogram) begin
        d = $urandom_range(0, 3);
        repeat (d) @(posedge clk);
        @(posedge clk);
        #1 histogramClear = 1'b1;
        @(posedge clk);
        #1 histogramClear = 1'b0;
      end else begin
        histogramClear = 1'b0;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model while a frame is live.
  always @(negedge clk) begin : compare
    int xi, xc, xl, xh, yi, yc, yl, yh, last_strobes, idle_run;
    bit xa, ya, ef;
    if (model_active) begin
      if (strobe_total != last_strobes) begin
        idle_run = 0;
        last_strobes = strobe_total;
      end else begin
        idle_run++;
      end
      modelAxis(1'b0, x_sent, xi, xc, xl, xh, xa);
      modelAxis(1'b1, y_sent, yi, yc, yl, yh, ya);
      ef = (xc >= THRESHOLD) && (yc >= THRESHOLD) && !exp_timeout && xa && ya;
      checkOutput("xPeak", xPeak, xi);
      checkOutput("xPeakCount", xPeakCount, xc);
      checkOutput("yPeak", yPeak, yi);
      checkOutput("yPeakCount", yPeakCount, yc);
`ifdef PEAK_BBOX_EN
      checkOutput("xMin", xMin, xl);
      checkOutput("xMax", xMax, xh);
      checkOutput("yMin", yMin, yl);
      checkOutput("yMax", yMax, yh);
`endif
      if (readHistogram) begin
        read_pulses++;
        checkOutput("timeoutErrAtRequest", timeoutErr, 0);
      end
      if (clearHistogram) begin
        clear_pulses++;
        if (exp_timeout) checkOutput("timeoutIdleCycles", idle_run, TIMEOUT);
      end
      if (done) begin
        done_pulses++;
        checkOutput("busyAtDone", busy, 1);
        checkOutput("foundAtDone", found, ef);
        checkOutput("timeoutErrAtDone", timeoutErr, exp_timeout);
        post_done = 1'b1;
      end else if (post_done) begin
        checkOutput("busyAfterDone", busy, 0);
        checkOutput("foundHeld", found, ef);
        checkOutput("timeoutErrHeld", timeoutErr, exp_timeout);
      end else begin
        checkOutput("busyInFrame", busy, 1);
        checkOutput("foundLowInFrame", found, 0);
      end
    end
  end

  task automatic fillRandom(input int maxv);
    for (int i = 0; i < X_BINS; i++) xb[i] = 8'($urandom_range(0, maxv));
    for (int i = 0; i < Y_BINS; i++) yb[i] = 8'($urandom_range(0, maxv));
  endtask

  task automatic fillConst(input logic [7:0] v);
    for (int i = 0; i < X_BINS; i++) xb[i] = v;
    for (int i = 0; i < Y_BINS; i++) yb[i] = v;
  endtask

  // Runs one frame: start, stream n_x/n_y bins with random gaps, wait for done.
  // abort_at >= 0 asserts reset (with start and strobes) at that stream cycle.
  task automatic applyStimulus(input int n_x, input int n_y, input int gap_pct, input bit extras,
                               input bit held, input int mid_start_at, input int abort_at);
    int xi, yi, cyc;
    bit xv, yv;
    model_active = 1'b0;
    post_done = 1'b0;
    x_sent = 0; y_sent = 0; strobe_total = 0;
    read_pulses = 0; clear_pulses = 0; done_pulses = 0;
    exp_timeout = (n_x < X_BINS) || (n_y < Y_BINS);
    clr_held = held;
    @(posedge clk); #1;
    start = 1'b1; histReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; model_active = 1'b1;
    @(posedge clk); #1;
    xi = 0; yi = 0; cyc = 0;
    while ((xi < n_x || yi < n_y) && cyc < 4000) begin
      xv = (xi < n_x) && ($urandom_range(0, 99) >= gap_pct);
      yv = (yi < n_y) && ($urandom_range(0, 99) >= gap_pct);
      xValid = 1'b0; yValid = 1'b0;
      if (xv) begin
        xValid = 1'b1; xHistogramIn = xb[xi];
      end else if (extras && xi == X_BINS && $urandom_range(0, 1) == 1) begin
        xValid = 1'b1; xHistogramIn = 8'hFF;
      end else begin
        xHistogramIn = 8'($urandom_range(0, 255));
      end
      if (yv) begin
        yValid = 1'b1; yHistogramIn = yb[yi];
      end else if (extras && yi == Y_BINS && $urandom_range(0, 1) == 1) begin
        yValid = 1'b1; yHistogramIn = 8'hFF;
      end else begin
        yHistogramIn = 8'($urandom_range(0, 255));
      end
      if (cyc == mid_start_at) start = 1'b1;
      if (cyc == abort_at) begin
        reset = 1'b1; start = 1'b1; xValid = 1'b1; yValid = 1'b1;
        model_active = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == abort_at) begin
        reset = 1'b0; xValid = 1'b0; yValid = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_read", readHistogram, 0);
        checkOutput("abort_clear", clearHistogram, 0);
        checkOutput("abort_found", found, 0);
        checkOutput("abort_timeoutErr", timeoutErr, 0);
        checkOutput("abort_xPeak", xPeak, 0);
        checkOutput("abort_xPeakCount", xPeakCount, 0);
        checkOutput("abort_yPeak", yPeak, 0);
        checkOutput("abort_yPeakCount", yPeakCount, 0);
        @(negedge clk);
        checkOutput("abort_startIgnored", busy, 0);
        return;
      end
      if (xv) xi++;
      if (yv) yi++;
      x_sent = xi; y_sent = yi;
      strobe_total += int'(xValid) + int'(yValid);
      cyc++;
    end
    xValid = 1'b0; yValid = 1'b0;
    cyc = 0;
    while (done_pulses == 0 && cyc < TIMEOUT + 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done_pulses == 0) checkOutput("doneSeen", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("readPulses", read_pulses, 1);
    checkOutput("clearPulses", clear_pulses, 1);
    checkOutput("donePulses", done_pulses, 1);
    clr_held = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; histReady = 1'b1;
    xValid = 1'b0; yValid = 1'b0; xHistogramIn = 8'd0; yHistogramIn = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_read", readHistogram, 0);
    checkOutput("reset_clear", clearHistogram, 0);
    checkOutput("reset_found", found, 0);
    checkOutput("reset_timeoutErr", timeoutErr, 0);
    checkOutput("reset_xPeakCount", xPeakCount, 0);
    @(posedge clk); #1 reset = 1'b0;

    // start while histogram stage is not ready must be ignored
    histReady = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; histReady = 1'b1;
    @(negedge clk);
    checkOutput("notReady_busy", busy, 0);
    checkOutput("notReady_read", readHistogram, 0);

    // single peaks on each axis
    fillConst(8'd0); xb[57] = 8'd120; yb[90] = 8'd200;
    applyStimulus(X_BINS, Y_BINS, 30, 1'b0, 1'b0, -1, -1);
    checkOutput("s1_xPeak", xPeak, 57);
    checkOutput("s1_xPeakCount", xPeakCount, 120);
    checkOutput("s1_yPeak", yPeak, 90);
    checkOutput("s1_yPeakCount", yPeakCount, 200);
    checkOutput("s1_found", found, 1);

    // tie keeps the lowest index
    fillConst(8'd0); xb[10] = 8'd50; xb[200] = 8'd50; yb[5] = 8'd9;
    applyStimulus(X_BINS, Y_BINS, 0, 1'b1, 1'b0, -1, -1);
    checkOutput("s2_xPeak", xPeak, 10);
    checkOutput("s2_xPeakCount", xPeakCount, 50);

    // all bins below threshold
    fillConst(8'd5);
    applyStimulus(X_BINS, Y_BINS, 20, 1'b0, 1'b1, -1, -1);
    checkOutput("s3_xPeakCount", xPeakCount, 5);
    checkOutput("s3_yPeakCount", yPeakCount, 5);
    checkOutput("s3_xPeak", xPeak, 0);
    checkOutput("s3_found", found, 0);

    // y stream stalls after 100 bins
    fillRandom(255);
    applyStimulus(X_BINS, 100, 10, 1'b0, 1'b0, -1, -1);
    checkOutput("s4_timeoutErr", timeoutErr, 1);
    checkOutput("s4_found", found, 0);

    // reset mid-collect, then a normal frame
    fillRandom(255);
    applyStimulus(X_BINS, Y_BINS, 20, 1'b0, 1'b0, -1, 60);
    applyStimulus(X_BINS, Y_BINS, 20, 1'b0, 1'b0, -1, -1);

`ifdef PEAK_BBOX_EN
    fillConst(8'd0);
    for (int i = 30; i <= 70; i++) xb[i] = 8'd20;
    yb[3] = 8'd40;
    applyStimulus(X_BINS, Y_BINS, 10, 1'b0, 1'b0, -1, -1);
    checkOutput("bbox_xMin", xMin, 30);
    checkOutput("bbox_xMax", xMax, 70);
    checkOutput("bbox_found", found, 1);
`endif

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      case (f % 3)
        0: fillRandom(255);
        1: fillRandom(10);
        default: fillRandom(7);
      endcase
      applyStimulus(X_BINS, Y_BINS, $urandom_range(0, 60), f[0], (f == 2),
                    (f == 3) ? 50 : -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/histogram_peak_finder.md
HISTOGRAM_PEAK_FINDER -- requirements
Module: histogram_peak_finder

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- X_BINS, 240, x-histogram bins per frame.
- Y_BINS, 180, y-histogram bins per frame.
- THRESHOLD, 8, minimum bin count for a valid peak/box.
- TIMEOUT, 1023, idle cycles tolerated while collecting.

REQ-002 Ports (name direction width meaning) SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins one frame analysis.
- histReady  in  1  histogram stage ready/idle.
- readHistogram  out  1  one-cycle pulse requesting bin stream.
- clearHistogram  out  1  one-cycle pulse clearing histogram.
- histogramClear  in  1  histogram clear-complete acknowledge.
- xHistogramIn  in  8  x-bin count; valid when xValid.
- xValid  in  1  x bin strobe.
- yHistogramIn  in  8  y-bin count; valid when yValid.
- yValid  in  1  y bin strobe.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle completion pulse.
- found  out  1  both peaks >= THRESHOLD; held until next start.
- timeoutErr  out  1  frame aborted on timeout; held until next start.
- xPeak, yPeak  out  8 each  bin index of maximum.
- xPeakCount, yPeakCount  out  8 each  maximum bin value.

Function
REQ-003 FSM states SHALL be IDLE, REQUEST, COLLECT, CLEAR, DONE.
REQ-004 IDLE->REQUEST on start while histReady=1; start with histReady=0 or when not IDLE SHALL be ignored.
REQ-005 REQUEST: readHistogram=1 for exactly one cycle; next state COLLECT.
REQ-006 COLLECT: x and y streams tracked independently by 8-bit bin counters from 0; each valid strobe advances its counter; both strobes may be active the same cycle.
REQ-007 Peak update only when value > running max (strict); ties keep lowest index; running max initialised to 0, index 0.
REQ-008 Strobes beyond X_BINS/Y_BINS in a frame SHALL be ignored (no counter wrap).
REQ-009 COLLECT->CLEAR when x counter = X_BINS and y counter = Y_BINS.
REQ-010 Idle counter resets on any strobe; reaching TIMEOUT with no strobe -> timeoutErr=1, go to CLEAR; peak outputs keep partial results.
REQ-011 CLEAR: clearHistogram=1 for one cycle on entry, then wait for histogramClear=1 -> DONE; histogramClear already high on entry is accepted on the next cycle.
REQ-012 DONE: done=1 one cycle; found registered = (xPeakCount>=THRESHOLD && yPeakCount>=THRESHOLD && !timeoutErr); -> IDLE.
REQ-013 Peak outputs update live during COLLECT and are stable from DONE until the next accepted start, which zeroes them.
REQ-014 busy=1 in all states except IDLE.

Reset
REQ-015 reset (synchronous, active-high) SHALL force IDLE, all outputs 0, counters 0 on the next clock edge, including mid-COLLECT or mid-CLEAR; no clearHistogram pulse is issued on reset.
REQ-016 Reset has priority over start and all strobes in the same cycle.

Configuration
REQ-017 Macro PEAK_BBOX_EN: when defined, adds outputs xMin, xMax, yMin, yMax (8 bits each) = first/last bin index with count >= THRESHOLD, reset/cleared to 0, and found additionally requires at least one qualifying bin per axis. When undefined, these ports and their logic do not exist and behaviour is per REQ-012.

Verification
REQ-018 Scenarios:
- x stream all 0 except bin 57=120, y all 0 except bin 90=200 -> xPeak=57, xPeakCount=120, yPeak=90, yPeakCount=200, found=1, one done pulse.
- x bins 10 and 200 both =50 -> xPeak=10 (tie keeps lowest).
- all bins =5 (THRESHOLD 8) -> counts=5, found=0, done pulses.
- x stream complete, y stream stopped after 100 bins -> timeoutErr=1 after 1023 idle cycles, clearHistogram pulse, done, found=0.
- reset asserted mid-COLLECT -> next cycle busy=0, all outputs 0; new start runs normally.
- PEAK_BBOX_EN, x bins 30..70 =20, others 0 -> xMin=30, xMax=70.
